// File: rtl/bcd_display_ctrl_pkg.sv
// Shared types and constants for the multiplexed BCD display controller.
package bcd_display_ctrl_pkg;

   typedef enum logic {
      StIdle    = 1'b0,
      StConvert = 1'b1
   } state_e;

   localparam int unsigned RefreshDivDefault = 50000;

   // Active-low segment patterns, bit order gfedcba.
   localparam logic [6:0] Seg0     = 7'b1000000;
   localparam logic [6:0] Seg1     = 7'b1111001;
   localparam logic [6:0] Seg2     = 7'b0100100;
   localparam logic [6:0] Seg3     = 7'b0110000;
   localparam logic [6:0] Seg4     = 7'b0011001;
   localparam logic [6:0] Seg5     = 7'b0010010;
   localparam logic [6:0] Seg6     = 7'b0000010;
   localparam logic [6:0] Seg7     = 7'b1111000;
   localparam logic [6:0] Seg8     = 7'b0000000;
   localparam logic [6:0] Seg9     = 7'b0010000;
   localparam logic [6:0] SegBlank = 7'b1111111;

   // Non-decimal codes cannot occur from the converter; map them to blank.
   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = Seg0;
         4'd1:    pattern = Seg1;
         4'd2:    pattern = Seg2;
         4'd3:    pattern = Seg3;
         4'd4:    pattern = Seg4;
         4'd5:    pattern = Seg5;
         4'd6:    pattern = Seg6;
         4'd7:    pattern = Seg7;
         4'd8:    pattern = Seg8;
         4'd9:    pattern = Seg9;
         default: pattern = SegBlank;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/bcd_display_ctrl_bcd.sv
// Combinational 13-bit binary to four-digit BCD converter (shift-and-add-3).
module bcd_display_ctrl_bcd
   import bcd_display_ctrl_pkg::*;
(
   input  logic [12:0] value_i,
   output logic [3:0]  ones_o,
   output logic [3:0]  tens_o,
   output logic [3:0]  hundreds_o,
   output logic [3:0]  thousands_o
);

   logic [15:0] shift;

   // Double-dabble: correct each nibble before every left shift of a new bit.
   always_comb begin
      shift = '0;
      for (int i = 12; i >= 0; i--) begin
         for (int d = 0; d < 4; d++) begin
            if (shift[4*d +: 4] >= 4'd5) begin
               shift[4*d +: 4] = shift[4*d +: 4] + 4'd3;
            end
         end
         shift = {shift[14:0], value_i[i]};
      end
   end

   assign ones_o      = shift[3:0];
   assign tens_o      = shift[7:4];
   assign hundreds_o  = shift[11:8];
   assign thousands_o = shift[15:12];

endmodule

// File: rtl/bcd_display_ctrl.sv
// Two-requester BCD display controller: round-robin grant, one-cycle conversion
// into digit registers, and a free-running multiplexed 4-digit scan.
module bcd_display_ctrl
   import bcd_display_ctrl_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = RefreshDivDefault
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_a,
   input  logic [12:0] data_a,
   input  logic        req_b,
   input  logic [12:0] data_b,
   output logic        ack_a,
   output logic        ack_b,
   output logic        busy,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

   state_e      state_q, state_d;
   logic [12:0] value_q, value_d;
   logic        ack_a_q, ack_a_d;
   logic        ack_b_q, ack_b_d;
   logic        last_b_q, last_b_d;  // 1: B was granted most recently
   logic [3:0]  ones_q, ones_d, tens_q, tens_d;
   logic [3:0]  hund_q, hund_d, thou_q, thou_d;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;

   logic [3:0] bcd_ones, bcd_tens, bcd_hund, bcd_thou;
   logic       grant_b;
   logic       blank_thou, blank_hund, blank_tens;

   bcd_display_ctrl_bcd u_bcd (
      .value_i     (value_q),
      .ones_o      (bcd_ones),
      .tens_o      (bcd_tens),
      .hundreds_o  (bcd_hund),
      .thousands_o (bcd_thou)
   );

   // On a tie, B wins only if A was granted last.
   assign grant_b = req_b & (~req_a | ~last_b_q);

   // Request arbitration, capture and digit conversion.
   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      ack_a_d  = 1'b0;
      ack_b_d  = 1'b0;
      last_b_d = last_b_q;
      ones_d   = ones_q;
      tens_d   = tens_q;
      hund_d   = hund_q;
      thou_d   = thou_q;
      unique case (state_q)
         StIdle: begin
            if (req_a || req_b) begin
               value_d  = grant_b ? data_b : data_a;
               ack_a_d  = ~grant_b;
               ack_b_d  = grant_b;
               last_b_d = grant_b;
               state_d  = StConvert;
            end
         end
         StConvert: begin
            ones_d  = bcd_ones;
            tens_d  = bcd_tens;
            hund_d  = bcd_hund;
            thou_d  = bcd_thou;
            state_d = StIdle;
         end
      endcase
   end

   assign blank_thou = (thou_q == 4'd0);
   assign blank_hund = blank_thou && (hund_q == 4'd0);
   assign blank_tens = blank_hund && (tens_q == 4'd0);

   // Scan counter and digit index; an/seg are computed from the next index so
   // they stay aligned with idx_q.
   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      idx_d = idx_q;
      if (cnt_q == CntMax) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
      unique case (idx_d)
         2'd0: begin
            an_d  = 4'b1110;
            seg_d = seg_encode(ones_q);
         end
         2'd1: begin
            an_d  = 4'b1101;
            seg_d = blank_tens ? SegBlank : seg_encode(tens_q);
         end
         2'd2: begin
            an_d  = 4'b1011;
            seg_d = blank_hund ? SegBlank : seg_encode(hund_q);
         end
         2'd3: begin
            an_d  = 4'b0111;
            seg_d = blank_thou ? SegBlank : seg_encode(thou_q);
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         value_q  <= '0;
         ack_a_q  <= 1'b0;
         ack_b_q  <= 1'b0;
         last_b_q <= 1'b1;
         ones_q   <= '0;
         tens_q   <= '0;
         hund_q   <= '0;
         thou_q   <= '0;
         cnt_q    <= '0;
         idx_q    <= 2'd0;
         an_q     <= 4'b1110;
         seg_q    <= Seg0;
      end else begin
         state_q  <= state_d;
         value_q  <= value_d;
         ack_a_q  <= ack_a_d;
         ack_b_q  <= ack_b_d;
         last_b_q <= last_b_d;
         ones_q   <= ones_d;
         tens_q   <= tens_d;
         hund_q   <= hund_d;
         thou_q   <= thou_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign ack_a = ack_a_q;
   assign ack_b = ack_b_q;
   assign busy  = (state_q == StConvert);
   assign seg   = seg_q;
   assign an    = an_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed self-checking bench for bcd_display_ctrl with a short refresh period.
module tb_bcd_display_ctrl;

   localparam int unsigned Div = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_a = 1'b0;
   logic [12:0] data_a = '0;
   logic        req_b = 1'b0;
   logic [12:0] data_b = '0;
   logic        ack_a, ack_b, busy;
   logic [6:0]  seg;
   logic [3:0]  an;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] s_one, s_ten, s_hun, s_tho;

   bcd_display_ctrl #(
      .REFRESH_DIV (Div)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .req_a  (req_a),
      .data_a (data_a),
      .req_b  (req_b),
      .data_b (data_b),
      .ack_a  (ack_a),
      .ack_b  (ack_b),
      .busy   (busy),
      .seg    (seg),
      .an     (an)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   // One full scan round; keeps the last seg seen under each anode.
   task automatic capture(output logic [6:0] c_one, output logic [6:0] c_ten,
                          output logic [6:0] c_hun, output logic [6:0] c_tho);
      c_one = 'x;
      c_ten = 'x;
      c_hun = 'x;
      c_tho = 'x;
      for (int k = 0; k < 4 * Div; k++) begin
         step();
         case (an)
            4'b1110: c_one = seg;
            4'b1101: c_ten = seg;
            4'b1011: c_hun = seg;
            4'b0111: c_tho = seg;
            default: ;
         endcase
      end
   endtask

   initial begin
      // Reset values.
      step();
      step();
      check("rst_an", 16'(an), 16'(4'b1110));
      check("rst_seg", 16'(seg), 16'(7'b1000000));
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_acks", 16'({ack_a, ack_b}), 16'd0);
      reset = 1'b0;

      // Idle scan of value 0: anode steps every Div cycles and wraps.
      for (int k = 0; k <= 4 * Div; k++) begin
         if (k > 0) step();
         check("scan_an", 16'(an), 16'(an_tab[(k / Div) % 4]));
         check("scan_seg", 16'(seg),
               ((k / Div) % 4 == 0) ? 16'(7'b1000000) : 16'(7'b1111111));
      end

      // Tie after reset: A first, B two cycles later.
      req_a = 1'b1; data_a = 13'd5;
      req_b = 1'b1; data_b = 13'd8191;
      step();
      check("tie1_ack_a", 16'(ack_a), 16'd1);
      check("tie1_ack_b", 16'(ack_b), 16'd0);
      check("tie1_busy", 16'(busy), 16'd1);
      req_a = 1'b0;
      step();
      check("tie1_conv_acks", 16'({ack_a, ack_b}), 16'd0);
      check("tie1_conv_busy", 16'(busy), 16'd0);
      step();
      check("tie1_ack_b2", 16'(ack_b), 16'd1);
      check("tie1_ack_a2", 16'(ack_a), 16'd0);
      req_b = 1'b0;
      step();
      step();
      capture(s_one, s_ten, s_hun, s_tho);
      check("d8191_one", 16'(s_one), 16'(7'b1111001));
      check("d8191_ten", 16'(s_ten), 16'(7'b0010000));
      check("d8191_hun", 16'(s_hun), 16'(7'b1111001));
      check("d8191_tho", 16'(s_tho), 16'(7'b0000000));

      // Single request from A with 1234.
      req_a = 1'b1; data_a = 13'd1234;
      step();
      check("a1234_ack", 16'(ack_a), 16'd1);
      check("a1234_busy", 16'(busy), 16'd1);
      req_a = 1'b0;
      step();
      check("a1234_ack_off", 16'(ack_a), 16'd0);
      check("a1234_busy_off", 16'(busy), 16'd0);
      step();
      step();
      capture(s_one, s_ten, s_hun, s_tho);
      check("d1234_one", 16'(s_one), 16'(7'b0011001));
      check("d1234_ten", 16'(s_ten), 16'(7'b0110000));
      check("d1234_hun", 16'(s_hun), 16'(7'b0100100));
      check("d1234_tho", 16'(s_tho), 16'(7'b1111001));

      // Tie after A was granted: B wins, then A (1005) is served.
      req_a = 1'b1; data_a = 13'd1005;
      req_b = 1'b1; data_b = 13'd7;
      step();
      check("tie2_ack_b", 16'(ack_b), 16'd1);
      check("tie2_ack_a", 16'(ack_a), 16'd0);
      req_b = 1'b0;
      step();
      check("tie2_conv_ack_a", 16'(ack_a), 16'd0);
      step();
      check("tie2_ack_a2", 16'(ack_a), 16'd1);
      req_a = 1'b0;
      step();
      step();
      capture(s_one, s_ten, s_hun, s_tho);
      check("d1005_one", 16'(s_one), 16'(7'b0010010));
      check("d1005_ten", 16'(s_ten), 16'(7'b1000000));
      check("d1005_hun", 16'(s_hun), 16'(7'b1000000));
      check("d1005_tho", 16'(s_tho), 16'(7'b1111001));

      // B alone with 7: upper three digits blank.
      req_b = 1'b1; data_b = 13'd7;
      step();
      check("b7_ack", 16'(ack_b), 16'd1);
      req_b = 1'b0;
      step();
      step();
      capture(s_one, s_ten, s_hun, s_tho);
      check("d7_one", 16'(s_one), 16'(7'b1111000));
      check("d7_ten", 16'(s_ten), 16'(7'b1111111));
      check("d7_hun", 16'(s_hun), 16'(7'b1111111));
      check("d7_tho", 16'(s_tho), 16'(7'b1111111));

      // Reset during conversion of 999 aborts it.
      req_a = 1'b1; data_a = 13'd999;
      step();
      check("r999_ack", 16'(ack_a), 16'd1);
      check("r999_busy", 16'(busy), 16'd1);
      reset = 1'b1;
      req_a = 1'b0;
      step();
      check("r999_rst_acks", 16'({ack_a, ack_b}), 16'd0);
      check("r999_rst_busy", 16'(busy), 16'd0);
      check("r999_rst_an", 16'(an), 16'(4'b1110));
      check("r999_rst_seg", 16'(seg), 16'(7'b1000000));
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("r999_no_ack", 16'({ack_a, ack_b}), 16'd0);
      end
      capture(s_one, s_ten, s_hun, s_tho);
      check("r999_one", 16'(s_one), 16'(7'b1000000));
      check("r999_ten", 16'(s_ten), 16'(7'b1111111));
      check("r999_hun", 16'(s_hun), 16'(7'b1111111));
      check("r999_tho", 16'(s_tho), 16'(7'b1111111));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
